// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache: 8 sets x 16-byte lines.
// Word hits complete combinationally; misses run optional write-back then line fill.
module l1_dcache (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [15:0]  mem_address_i,
  input  logic         mem_read_i,
  input  logic         mem_write_i,
  input  logic [1:0]   mem_byte_enable_i,
  input  logic [15:0]  mem_wdata_i,
  output logic [15:0]  mem_rdata_o,
  output logic         mem_resp_o,
  output logic [15:0]  pmem_address_o,
  output logic         pmem_read_o,
  output logic         pmem_write_o,
  output logic [127:0] pmem_wdata_o,
  input  logic [127:0] pmem_rdata_i,
  input  logic         pmem_resp_i
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [7:0]   valid_q, valid_d;
  logic [7:0]   dirty_q, dirty_d;
  logic [8:0]   tag_q  [8];
  logic [127:0] data_q [8];

  logic [8:0]   req_tag;
  logic [2:0]   idx;
  logic [2:0]   off;
  logic [6:0]   lsb;
  logic         req;
  logic         hit;
  logic [127:0] cur_line;
  logic [127:0] merged_line;
  logic         hit_we;
  logic         fill_we;
  logic         unused_addr_bit;

  assign req_tag         = mem_address_i[15:7];
  assign idx             = mem_address_i[6:4];
  assign off             = mem_address_i[3:1];
  assign lsb             = {off, 4'b0000};
  assign unused_addr_bit = mem_address_i[0];
  assign req             = mem_read_i | mem_write_i;
  assign hit             = valid_q[idx] && (tag_q[idx] == req_tag);
  assign cur_line        = data_q[idx];

  always_comb begin
    merged_line = cur_line;
    if (mem_byte_enable_i[0]) merged_line[lsb +: 8]         = mem_wdata_i[7:0];
    if (mem_byte_enable_i[1]) merged_line[lsb + 7'd8 +: 8]  = mem_wdata_i[15:8];
  end

  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    dirty_d        = dirty_q;
    mem_resp_o     = 1'b0;
    mem_rdata_o    = 16'h0000;
    pmem_address_o = 16'h0000;
    pmem_read_o    = 1'b0;
    pmem_write_o   = 1'b0;
    pmem_wdata_o   = '0;
    hit_we         = 1'b0;
    fill_we        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp_o  = 1'b1;
            mem_rdata_o = cur_line[lsb +: 16];
            if (mem_write_i) begin
              hit_we = 1'b1;
              // an all-zero mask leaves the line untouched, so it stays clean
              if (mem_byte_enable_i != 2'b00) dirty_d[idx] = 1'b1;
            end
          end else if (valid_q[idx] && dirty_q[idx]) begin
            state_d = WRITEBACK;
          end else begin
            state_d = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        pmem_write_o   = 1'b1;
        pmem_address_o = {tag_q[idx], idx, 4'b0000};
        pmem_wdata_o   = cur_line;
        if (pmem_resp_i) begin
          dirty_d[idx] = 1'b0;
          state_d      = ALLOCATE;
        end
      end
      ALLOCATE: begin
        pmem_read_o    = 1'b1;
        pmem_address_o = {req_tag, idx, 4'b0000};
        if (pmem_resp_i) begin
          fill_we      = 1'b1;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= 8'h00;
      dirty_q <= 8'h00;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // tag/data arrays carry no reset; valid bits guard their contents
  always_ff @(posedge clk_i) begin
    if (fill_we) begin
      data_q[idx] <= pmem_rdata_i;
      tag_q[idx]  <= req_tag;
    end else if (hit_we) begin
      data_q[idx] <= merged_line;
    end
  end

endmodule

// File: tb/tb_l1_dcache.sv
// Randomized bench for l1_dcache: flat-memory reference model plus a cache
// occupancy model predicting hit/miss, write-back and latency for each access.
module tb_l1_dcache;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  l1_dcache dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .mem_address_i     (mem_address),
    .mem_read_i        (mem_read),
    .mem_write_i       (mem_write),
    .mem_byte_enable_i (mem_byte_enable),
    .mem_wdata_i       (mem_wdata),
    .mem_rdata_o       (mem_rdata),
    .mem_resp_o        (mem_resp),
    .pmem_address_o    (pmem_address),
    .pmem_read_o       (pmem_read),
    .pmem_write_o      (pmem_write),
    .pmem_wdata_o      (pmem_wdata),
    .pmem_rdata_i      (pmem_rdata),
    .pmem_resp_i       (pmem_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference: CPU-visible memory, backing memory, and which line each set holds
  logic [15:0] bmem [32768];
  logic [15:0] refm [32768];
  logic        m_valid [8];
  logic        m_dirty [8];
  logic [8:0]  m_tag   [8];

  int           fixed_lat, lat, cnt, last_w_lat, last_r_lat;
  logic         wb_seen, rd_seen;
  logic [15:0]  wb_addr, rd_addr;
  logic [127:0] wb_data;

  function automatic int next_lat();
    return (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
  endfunction

  task automatic set_lat(input int n);
    fixed_lat = n;
    lat       = next_lat();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    for (int i = 0; i < 32768; i++) refm[i] = bmem[i];
  endtask

  // physical memory: answers after 'lat' strobe-high cycles with a one-cycle pulse
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    cnt        = 0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (rst || !(pmem_read || pmem_write)) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt >= lat) begin
          pmem_resp = 1'b1;
          if (pmem_write) begin
            wb_seen    = 1'b1;
            wb_addr    = pmem_address;
            wb_data    = pmem_wdata;
            last_w_lat = lat;
            for (int k = 0; k < 8; k++)
              bmem[{pmem_address[15:4], 3'(k)}] = pmem_wdata[16*k +: 16];
          end else begin
            rd_seen    = 1'b1;
            rd_addr    = pmem_address;
            last_r_lat = lat;
            for (int k = 0; k < 8; k++)
              pmem_rdata[16*k +: 16] = bmem[{pmem_address[15:4], 3'(k)}];
          end
          cnt = 0;
          lat = next_lat();
        end
      end
    end
  end

  // one CPU access, started at a negedge; returns at the negedge after mem_resp
  task automatic cpu_access(input logic rd, input logic wr, input logic [15:0] a,
                            input logic [1:0] be, input logic [15:0] wd,
                            input string tag, output logic [15:0] rdata_out);
    logic [2:0]   idx    = a[6:4];
    logic [8:0]   tg     = a[15:7];
    logic [14:0]  w      = a[15:1];
    logic         hit    = m_valid[idx] && (m_tag[idx] == tg);
    logic         exp_wb = !hit && m_valid[idx] && m_dirty[idx];
    logic [15:0]  exp_rd = refm[w];
    logic [127:0] exp_line;
    logic         both_seen = 1'b0;
    logic         done = 1'b0;
    int           cycles = 0;
    int           expc;
    for (int k = 0; k < 8; k++) exp_line[16*k +: 16] = refm[{m_tag[idx], idx, 3'(k)}];
    wb_seen = 1'b0;
    rd_seen = 1'b0;
    rdata_out = 16'h0000;
    mem_address     = a;
    mem_read        = rd;
    mem_write       = wr;
    mem_byte_enable = be;
    mem_wdata       = wd;
    while (!done && cycles < 200) begin
      #2;
      cycles++;
      if (pmem_read && pmem_write) both_seen = 1'b1;
      if (mem_resp) begin
        done      = 1'b1;
        rdata_out = mem_rdata;
      end
      @(negedge clk);
    end
    check({tag, " resp"}, done, 1'b1);
    expc = hit ? 1 : (exp_wb ? 2 + last_w_lat + last_r_lat : 2 + last_r_lat);
    check({tag, " cycles"}, cycles, expc);
    check({tag, " wb_issued"}, wb_seen, exp_wb);
    check({tag, " fill_issued"}, rd_seen, !hit);
    check({tag, " strobe_overlap"}, both_seen, 1'b0);
    if (exp_wb) begin
      check({tag, " wb_addr"}, wb_addr, {m_tag[idx], idx, 4'b0000});
      check({tag, " wb_data"}, wb_data, exp_line);
    end
    if (!hit) check({tag, " fill_addr"}, rd_addr, {tg, idx, 4'b0000});
    if (rd && !wr) check({tag, " rdata"}, rdata_out, exp_rd);
    if (!hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 1'b0;
    end
    if (wr) begin
      if (be[0]) refm[w][7:0]  = wd[7:0];
      if (be[1]) refm[w][15:8] = wd[15:8];
      if (be != 2'b00) m_dirty[idx] = 1'b1;
    end
  endtask

  logic [8:0] tg_tab [4];

  initial begin
    logic [15:0] r;
    logic [15:0] a;
    int          op;
    tg_tab = '{9'h024, 9'h025, 9'h1A3, 9'h0FF};
    mem_read = 1'b0; mem_write = 1'b0; mem_address = 16'h0000;
    mem_byte_enable = 2'b00; mem_wdata = 16'h0000;
    rst = 1'b1;
    fixed_lat = 3; lat = 3; last_w_lat = 0; last_r_lat = 0;
    wb_seen = 1'b0; rd_seen = 1'b0; wb_addr = '0; rd_addr = '0; wb_data = '0;
    for (int i = 0; i < 32768; i++) bmem[i] = 16'($urandom);
    bmem[16'h1234 >> 1] = 16'hABCD;
    model_reset();

    repeat (3) @(negedge clk);
    #2;
    check("reset mem_resp", mem_resp, 1'b0);
    check("reset pmem_read", pmem_read, 1'b0);
    check("reset pmem_write", pmem_write, 1'b0);
    check("reset pmem_address", pmem_address, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    set_lat(3);
    cpu_access(1'b1, 1'b0, 16'h1234, 2'b00, 16'h0000, "cold_rd", r);
    check("cold_rd value", r, 16'hABCD);
    check("cold_rd fill addr", rd_addr, 16'h1230);

    cpu_access(1'b0, 1'b1, 16'h1235, 2'b10, 16'h55EE, "wr_hit_hi", r);
    cpu_access(1'b1, 1'b0, 16'h1234, 2'b00, 16'h0000, "rd_after_wr", r);
    check("rd_after_wr value", r, 16'h55CD);

    cpu_access(1'b1, 1'b0, 16'h12B4, 2'b00, 16'h0000, "evict", r);
    check("evict wb addr", wb_addr, 16'h1230);
    check("evict wb word2", wb_data[47:32], 16'h55CD);
    check("evict fill addr", rd_addr, 16'h12B0);

    cpu_access(1'b0, 1'b1, 16'h12B4, 2'b00, 16'hFFFF, "wr_mask0", r);
    cpu_access(1'b1, 1'b0, 16'h1234, 2'b00, 16'h0000, "clean_conflict", r);
    check("clean_conflict no wb", wb_seen, 1'b0);
    check("clean_conflict value", r, 16'h55CD);

    // reset in the middle of a line fill
    set_lat(10);
    mem_address = 16'h4000;
    mem_read    = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("mid_fill pmem_read", pmem_read, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_fill pmem_read", pmem_read, 1'b0);
    check("rst_fill pmem_write", pmem_write, 1'b0);
    check("rst_fill mem_resp", mem_resp, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    mem_read = 1'b0;
    model_reset();
    set_lat(3);
    cpu_access(1'b1, 1'b0, 16'h1234, 2'b00, 16'h0000, "post_rst_rd", r);
    check("post_rst misses", rd_seen, 1'b1);

    cpu_access(1'b1, 1'b1, 16'h1234, 2'b11, 16'hBEEF, "rd_wr_both", r);
    cpu_access(1'b1, 1'b0, 16'h1234, 2'b00, 16'h0000, "both_readback", r);
    check("both_readback value", r, 16'hBEEF);

    set_lat(0);
    for (int n = 0; n < 400; n++) begin
      a  = {tg_tab[$urandom_range(0, 3)], 3'($urandom), 3'($urandom), 1'($urandom)};
      op = int'($urandom_range(0, 2));
      cpu_access(op != 1, op != 0, a, 2'($urandom), 16'($urandom), "rand", r);
    end

    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    #2;
    check("idle mem_resp", mem_resp, 1'b0);
    check("idle pmem_read", pmem_read, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
